// File: rtl/hack_pkg.sv
// hack_pkg: shared types and I/O address map for the Hack data memory stage
package hack_pkg;
  localparam int DW = 16;
  localparam int AW = 15;
  typedef logic [DW-1:0] word_t;
  localparam logic [AW-1:0] ADDR_KBD = 15'h6000;
  localparam logic [AW-1:0] ADDR_LED = 15'h6001;
  localparam logic [AW-1:0] ADDR_TX = 15'h6002;
  localparam logic [AW-1:0] ADDR_STATUS = 15'h6003;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with occupancy count for distinct full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/hack_data_mem.sv
// hack_data_mem: Hack data RAM plus KBD/LED/TX-FIFO/STATUS memory-mapped I/O
module hack_data_mem
  import hack_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 15,
  parameter int RAM_DEPTH = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          en25m,
  input  logic          writeM,
  input  logic [DW-1:0] outM,
  input  logic [AW-1:0] addressM,
  output logic [DW-1:0] inM,
  input  logic          key_valid,
  input  logic [DW-1:0] key_code,
  output logic [DW-1:0] led,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);
  localparam int RW = $clog2(RAM_DEPTH);
  logic [DW-1:0] ram [RAM_DEPTH];
  logic [DW-1:0] ram_q, io_q, io_rd, kbd, status;
  logic sel_ram, sel_kbd, sel_led, sel_tx, sel_status, rd_ram;
  logic wr, full, empty, ovf, pop, push, drop;
  always_comb begin
    sel_ram = addressM < AW'(RAM_DEPTH);
    sel_kbd = 1'b0;
    sel_led = 1'b0;
    sel_tx = 1'b0;
    sel_status = 1'b0;
    io_rd = '0;
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
    case (addressM)
      ADDR_KBD: begin sel_kbd = 1'b1; io_rd = kbd; end
      ADDR_LED: begin sel_led = 1'b1; io_rd = led; end
      ADDR_TX: sel_tx = 1'b1;
      ADDR_STATUS: begin sel_status = 1'b1; io_rd = status; end
      default: io_rd = '0;
    endcase
  end
  assign wr = en25m && writeM;
  assign tx_valid = !empty;
  assign pop = tx_valid && tx_ready;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign push = wr && sel_tx && (!full || pop);
  assign drop = wr && sel_tx && full && !pop;
  assign inM = rd_ram ? ram_q : io_q;
  always_ff @(posedge clk50m) begin
    if (wr && sel_ram) ram[addressM[RW-1:0]] <= outM;
    if (!en25m) ram_q <= ram[addressM[RW-1:0]];
  end
  always_ff @(posedge clk50m)
    if (rst) begin
      io_q <= '0;
      rd_ram <= 1'b0;
      led <= '0;
      kbd <= '0;
      ovf <= 1'b0;
    end else begin
      if (!en25m) begin
        io_q <= io_rd;
        rd_ram <= sel_ram;
      end
      if (wr && sel_led) led <= outM;
      if (key_valid) kbd <= key_code;
      else if (wr && sel_kbd) kbd <= '0;
      if (drop) ovf <= 1'b1;
      else if (wr && sel_status) ovf <= 1'b0;
    end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk50m),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(outM[7:0]),
    .dout(tx_data),
    .full(full),
    .empty(empty)
  );
endmodule
